el2_exu_mul_pipe: RTL and testbench

EL2_EXU_MUL_PIPE -- requirements
Module: el2_exu_mul_pipe

---
 rtl/el2_exu_mul_pipe.sv | 164 ++++++++++++++++
 tb/tb_el2_exu_mul_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/el2_exu_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : el2_exu_mul_pipe
// Brief    : Pipelined RV M-extension multiplier (MUL/MULH/MULHSU/MULHU).
//            Each stage folds one chunk of rs1 into a running product.
// Revision : 1.0
// ============================================================================
module el2_exu_mul_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             scan_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [XLEN-1:0]  rs1_in,
    input  logic [XLEN-1:0]  rs2_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int         c_CHUNK_W   = (XLEN + STAGES - 1) / STAGES;
    localparam int         c_APAD_W    = STAGES * c_CHUNK_W;
    localparam int         c_PROD_W    = 2 * XLEN;
    localparam logic [1:0] c_OP_MUL    = 2'b00;
    localparam logic [1:0] c_OP_MULH   = 2'b01;
    localparam logic [1:0] c_OP_MULHSU = 2'b10;

    // Unsigned chunk k of the low XLEN bits of rs1 (zero padded at the top).
    function automatic logic [c_CHUNK_W-1:0] f_chunk(input logic [XLEN-1:0] a, input int k);
        logic [c_APAD_W-1:0] v_pad;
        v_pad = c_APAD_W'(a);
        return v_pad[k*c_CHUNK_W +: c_CHUNK_W];
    endfunction

    function automatic logic [c_PROD_W-1:0] f_pp(input logic [c_CHUNK_W-1:0] c,
                                                 input logic [c_PROD_W-1:0]  b);
        return c_PROD_W'(c) * b;
    endfunction

    logic                w_stall;
    logic                w_accept;
    logic                w_a_neg;
    logic                w_b_sgn;
    logic [c_PROD_W-1:0] w_b_ext;
    logic [c_PROD_W-1:0] w_acc_head;
    logic [STAGES-1:0]   w_valid;
    logic [STAGES-1:0]   w_hi;
    logic [TAG_W-1:0]    w_tag [STAGES];
    logic [c_PROD_W-1:0] w_acc [STAGES];
    logic [XLEN-1:0]     w_a   [STAGES];
    logic [c_PROD_W-1:0] w_b   [STAGES];
    logic                w_unused_scan;

    assign w_unused_scan = scan_mode;

    assign out_valid = w_valid[STAGES-1];
    assign w_stall   = out_valid & ~out_ready;
    assign in_ready  = ~flush & ~w_stall;
    assign w_accept  = in_valid & in_ready;
    assign busy      = |w_valid;

    assign w_a_neg = ((in_op == c_OP_MULH) | (in_op == c_OP_MULHSU)) & rs1_in[XLEN-1];
    assign w_b_sgn = (in_op == c_OP_MULH) & rs2_in[XLEN-1];
    assign w_b_ext = {{XLEN{w_b_sgn}}, rs2_in};

    // A negative rs1 equals its unsigned low bits minus 2^XLEN; that
    // correction term is applied once, up front, alongside chunk 0.
    assign w_acc_head = f_pp(f_chunk(rs1_in, 0), w_b_ext)
                      - ({c_PROD_W{w_a_neg}} & (w_b_ext << XLEN));

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic                r_valid;
        logic                r_hi;
        logic [TAG_W-1:0]    r_tag;
        logic [c_PROD_W-1:0] r_acc;
        logic                w_in_valid;
        logic                w_in_hi;
        logic [TAG_W-1:0]    w_in_tag;
        logic [c_PROD_W-1:0] w_in_acc;

        if (s == 0) begin : g_head
            assign w_in_valid = w_accept;
            assign w_in_hi    = (in_op != c_OP_MUL);
            assign w_in_tag   = in_tag;
            assign w_in_acc   = w_acc_head;
        end else begin : g_body
            assign w_in_valid = w_valid[s-1];
            assign w_in_hi    = w_hi[s-1];
            assign w_in_tag   = w_tag[s-1];
            assign w_in_acc   = w_acc[s-1]
                              + (f_pp(f_chunk(w_a[s-1], s), w_b[s-1]) << (s * c_CHUNK_W));
        end

        // Flush beats stall; bubbles advance without touching data.
        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                r_valid <= 1'b0;
                r_hi    <= 1'b0;
                r_tag   <= '0;
                r_acc   <= '0;
            end else if (flush) begin
                r_valid <= 1'b0;
            end else if (!w_stall) begin
                r_valid <= w_in_valid;
                if (w_in_valid) begin
                    r_hi  <= w_in_hi;
                    r_tag <= w_in_tag;
                    r_acc <= w_in_acc;
                end
            end
        end

        assign w_valid[s] = r_valid;
        assign w_hi[s]    = r_hi;
        assign w_tag[s]   = r_tag;
        assign w_acc[s]   = r_acc;

        if (s < STAGES - 1) begin : g_opnd
            logic [XLEN-1:0]     r_a;
            logic [c_PROD_W-1:0] r_b;
            logic [XLEN-1:0]     w_in_a;
            logic [c_PROD_W-1:0] w_in_b;

            if (s == 0) begin : g_from_port
                assign w_in_a = rs1_in;
                assign w_in_b = w_b_ext;
            end else begin : g_from_prev
                assign w_in_a = w_a[s-1];
                assign w_in_b = w_b[s-1];
            end

            always_ff @(posedge clk or negedge rst_l) begin
                if (!rst_l) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (!flush && !w_stall && w_in_valid) begin
                    r_a <= w_in_a;
                    r_b <= w_in_b;
                end
            end

            assign w_a[s] = r_a;
            assign w_b[s] = r_b;
        end else begin : g_tail
            assign w_a[s] = '0;
            assign w_b[s] = '0;
        end
    end

    assign out_result = w_hi[STAGES-1] ? w_acc[STAGES-1][c_PROD_W-1:XLEN]
                                       : w_acc[STAGES-1][XLEN-1:0];
    assign out_tag    = w_tag[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_el2_exu_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_el2_exu_mul_pipe
// Brief    : Self-checking bench for el2_exu_mul_pipe with a queue-based
//            reference model (in-order, fixed-latency, global stall).
// Revision : 1.0
// ============================================================================
module tb_el2_exu_mul_pipe;

    localparam int XLEN   = 32;
    localparam int STAGES = 3;
    localparam int TAG_W  = 5;

    logic             clk;
    logic             rst_l;
    logic             scan_mode;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic [XLEN-1:0]  rs1_in;
    logic [XLEN-1:0]  rs2_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    el2_exu_mul_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) u_dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .scan_mode  (scan_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .rs1_in     (rs1_in),
        .rs2_in     (rs2_in),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    typedef struct { logic [TAG_W-1:0] tag; logic [XLEN-1:0] res; int rem; } exp_t;
    typedef struct { logic [1:0] op; logic [XLEN-1:0] a; logic [XLEN-1:0] b; logic [TAG_W-1:0] tag; } req_t;

    exp_t            q_exp[$];
    req_t            q_req[$];
    logic [XLEN-1:0] obs_res[$];
    logic [TAG_W-1:0] obs_tag[$];
    int              obs_cyc[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   a0       = 0;
    int   nlow     = 0;
    logic last_acc;
    logic last_in_ready;

    function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] ea, eb, p;
        ea = (op == 2'b01 || op == 2'b10) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
        eb = (op == 2'b01) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return {{(XLEN-1){1'b0}}, 1'b1};
            2:       return '1;
            3:       return {1'b1, {(XLEN-1){1'b0}}};
            4:       return {1'b0, {(XLEN-1){1'b1}}};
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [63:0] res_at(input int i);
        if (i < obs_res.size()) return 64'(obs_res[i]);
        return 'x;
    endfunction

    function automatic logic [63:0] tag_at(input int i);
        if (i < obs_tag.size()) return 64'(obs_tag[i]);
        return 'x;
    endfunction

    function automatic logic [63:0] cyc_at(input int i);
        if (i < obs_cyc.size()) return 64'(obs_cyc[i]);
        return 'x;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic clear_obs();
        obs_res.delete();
        obs_tag.delete();
        obs_cyc.delete();
    endtask

    task automatic push_req(input logic [1:0] op, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
        req_t r;
        r.op = op; r.a = a; r.b = b; r.tag = tag;
        q_req.push_back(r);
    endtask

    // One clock: compare against the model mid-cycle, then advance the model.
    task automatic cycle();
        logic ev, er, stall;
        exp_t e;
        @(negedge clk);
        ev = (q_exp.size() > 0) && (q_exp[0].rem == 0);
        er = !flush && !(ev && !out_ready);
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("in_ready", 64'(in_ready), 64'(er));
        chk("busy", 64'(busy), 64'(q_exp.size() > 0));
        if (ev) begin
            chk("out_tag", 64'(out_tag), 64'(q_exp[0].tag));
            chk("out_result", 64'(out_result), 64'(q_exp[0].res));
        end
        last_in_ready = in_ready;
        last_acc      = in_valid && in_ready;
        if (last_acc) acc_cyc = cyc;
        if (out_valid && out_ready) begin
            obs_res.push_back(out_result);
            obs_tag.push_back(out_tag);
            obs_cyc.push_back(cyc);
        end
        if (flush) begin
            q_exp.delete();
        end else begin
            stall = ev && !out_ready;
            if (!stall) begin
                if (ev) void'(q_exp.pop_front());
                for (int i = 0; i < q_exp.size(); i++)
                    if (q_exp[i].rem > 0) q_exp[i].rem = q_exp[i].rem - 1;
                if (in_valid && er) begin
                    e.tag = in_tag;
                    e.res = ref_mul(in_op, rs1_in, rs2_in);
                    e.rem = STAGES - 1;
                    q_exp.push_back(e);
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic offer_cycle();
        if (q_req.size() > 0) begin
            in_valid = 1'b1;
            in_op    = q_req[0].op;
            rs1_in   = q_req[0].a;
            rs2_in   = q_req[0].b;
            in_tag   = q_req[0].tag;
        end else begin
            in_valid = 1'b0;
        end
        cycle();
        if (last_acc) void'(q_req.pop_front());
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((q_req.size() > 0 || q_exp.size() > 0 || busy) && n < max_cyc) begin
            offer_cycle();
            n++;
        end
        in_valid = 1'b0;
        chk("drain_idle", 64'(busy), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_l = 1'b0; scan_mode = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_tag = '0;
        rs1_in = '0; rs2_in = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_out_result", 64'(out_result), 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        rst_l = 1'b1;
        cycle();
        chk("rst_in_ready", 64'(last_in_ready), 64'(1));

        // Single MUL, latency and value
        clear_obs();
        push_req(2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3);
        offer_cycle();
        chk("mul_accept", 64'(last_acc), 64'(1));
        a0 = acc_cyc;
        repeat (5) offer_cycle();
        chk("mul_count", 64'(obs_res.size()), 64'(1));
        chk("mul_result", res_at(0), 64'h0000_0000_FFFF_FFEB);
        chk("mul_tag", tag_at(0), 64'(3));
        chk("mul_latency", cyc_at(0), 64'(a0 + 3));

        // High-half variants on the most negative operand
        clear_obs();
        push_req(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd10);
        push_req(2'b10, 32'h8000_0000, 32'h8000_0000, 5'd11);
        push_req(2'b11, 32'h8000_0000, 32'h8000_0000, 5'd12);
        drain(20);
        chk("hi_count", 64'(obs_res.size()), 64'(3));
        chk("mulh_result", res_at(0), 64'h4000_0000);
        chk("mulhsu_result", res_at(1), 64'hC000_0000);
        chk("mulhu_result", res_at(2), 64'h4000_0000);
        chk("mulhsu_tag", tag_at(1), 64'(11));

        // Eight back-to-back operations
        clear_obs();
        for (int i = 0; i < 8; i++)
            push_req(2'($urandom_range(0, 3)), rnd_opnd(), rnd_opnd(), TAG_W'(i));
        drain(30);
        chk("b2b_count", 64'(obs_res.size()), 64'(8));
        for (int i = 0; i < 8; i++) begin
            chk("b2b_tag", tag_at(i), 64'(i));
            chk("b2b_consecutive", cyc_at(i), cyc_at(0) + 64'(i));
        end

        // Consumer stalls for five cycles
        clear_obs();
        out_ready = 1'b0;
        nlow = 0;
        for (int i = 0; i < 4; i++)
            push_req(2'b00, 32'(i + 3), 32'h0001_0001, TAG_W'(20 + i));
        for (int i = 0; i < 5; i++) begin
            offer_cycle();
            if (!last_in_ready) nlow++;
        end
        chk("stall_ready_low", 64'(nlow), 64'(2));
        chk("stall_no_out", 64'(obs_res.size()), 64'(0));
        chk("stall_held_tag", 64'(out_tag), 64'(20));
        out_ready = 1'b1;
        drain(30);
        chk("stall_count", 64'(obs_res.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            chk("stall_order", tag_at(i), 64'(20 + i));
        chk("stall_result0", res_at(0), 64'h0003_0003);

        // Flush one cycle after issuing two operations
        clear_obs();
        push_req(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 5'd1);
        push_req(2'b00, 32'h0000_0011, 32'h0000_0022, 5'd2);
        offer_cycle();
        offer_cycle();
        flush = 1'b1; in_valid = 1'b1; in_tag = 5'd3; in_op = 2'b00;
        cycle();
        chk("flush_in_ready", 64'(last_in_ready), 64'(0));
        chk("flush_no_accept", 64'(last_acc), 64'(0));
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_busy", 64'(busy), 64'(0));
        repeat (6) cycle();
        chk("flush_no_out", 64'(obs_res.size()), 64'(0));

        // Randomized traffic with backpressure, flushes and scan toggling
        clear_obs();
        for (int k = 0; k < 400; k++) begin
            if (q_req.size() < 2 && $urandom_range(0, 3) != 0)
                push_req(2'($urandom_range(0, 3)), rnd_opnd(), rnd_opnd(), TAG_W'(k));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            scan_mode = 1'($urandom_range(0, 1));
            offer_cycle();
        end
        flush = 1'b0; out_ready = 1'b1; scan_mode = 1'b0;
        drain(60);

        // Asynchronous reset with work in flight
        clear_obs();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            push_req(2'b00, 32'd5, 32'(9 + i), TAG_W'(4 + i));
        repeat (4) offer_cycle();
        in_valid = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        #2;
        rst_l = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_out_result", 64'(out_result), 64'(0));
        chk("arst_out_tag", 64'(out_tag), 64'(0));
        q_exp.delete();
        q_req.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_l = 1'b1;
        clear_obs();
        push_req(2'b00, 32'h0001_2345, 32'h0000_0010, 5'd9);
        offer_cycle();
        chk("post_rst_accept", 64'(last_acc), 64'(1));
        a0 = acc_cyc;
        drain(20);
        chk("post_rst_count", 64'(obs_res.size()), 64'(1));
        chk("post_rst_tag", tag_at(0), 64'(9));
        chk("post_rst_result", res_at(0), 64'h0012_3450);
        chk("post_rst_latency", cyc_at(0), 64'(a0 + 3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
